// File: rtl/fifo_unpack_pkg.sv
// fifo_unpack_pkg -- shared types and helpers for the FIFO word unpacker.
package fifo_unpack_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Number of output chunks carried by one FIFO word.
    function automatic int nchunk(input int data_w, input int out_w);
        return data_w / out_w;
    endfunction

    // Word must split evenly into at least two chunks; two chunks per word is
    // what keeps pops at least two cycles apart and hides the FIFO read lag.
    function automatic bit params_ok(input int data_w, input int out_w);
        return (out_w > 0) && ((data_w % out_w) == 0) && ((data_w / out_w) >= 2);
    endfunction

endpackage

// File: rtl/fifo_unpack.sv
// fifo_unpack -- pops words from a registered-read synchronous FIFO and
// streams each one out LSB chunk first on a valid/ready interface.
// Optional macro FIFO_UNPACK_LAST_EN adds the out_last port (final chunk flag).
module fifo_unpack
    import fifo_unpack_pkg::*;
#(
    parameter int DATA_WIDTH = 72,
    parameter int OUT_WIDTH  = 8
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              flush,
    input  logic [DATA_WIDTH-1:0]                             fifo_dout,
    input  logic                                              fifo_empty,
    output logic                                              fifo_rd_en,
    output logic [OUT_WIDTH-1:0]                              out_data,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [$clog2(nchunk(DATA_WIDTH, OUT_WIDTH))-1:0]  chunk_idx,
`ifdef FIFO_UNPACK_LAST_EN
    output logic                                              out_last,
`endif
    output logic                                              busy
);

    localparam int NCHUNK = nchunk(DATA_WIDTH, OUT_WIDTH);
    localparam int CW     = $clog2(NCHUNK);

    if (!params_ok(DATA_WIDTH, OUT_WIDTH)) begin : g_param_check
        $error("fifo_unpack: DATA_WIDTH must be a multiple of OUT_WIDTH with at least 2 chunks");
    end

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_sreg;
    logic [CW-1:0]           r_cnt;
    logic                    r_holdoff;
    logic                    w_pop_ok;
    logic                    w_last_chunk;
    logic                    w_accept;
    logic                    w_rd_en;
    logic                    w_load;
    logic                    w_shift;

    // holdoff masks the cycle where the FIFO's dout/empty still show pre-pop
    // (or pre-clear) values; rst_n gating keeps the pop strobe quiet in reset.
    assign w_pop_ok     = rst_n && !fifo_empty && !r_holdoff && !flush;
    assign w_last_chunk = (r_cnt == CW'(NCHUNK - 1));
    assign w_accept     = (r_state == SHIFT) && out_ready;

    // Next-state and pop/load/shift decisions; flush overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pop_ok) begin
                    w_rd_en     = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_accept) begin
                    if (!w_last_chunk) begin
                        w_shift = 1'b1;
                    end else if (w_pop_ok) begin
                        // Reload on the final accept so the next word follows with no bubble.
                        w_rd_en = 1'b1;
                        w_load  = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
            w_rd_en     = 1'b0;
            w_load      = 1'b0;
            w_shift     = 1'b0;
        end
    end

    // State register and read-lag holdoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_holdoff <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_holdoff <= w_rd_en | flush;
        end
    end

    // Word shifter and chunk counter; both hold while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (flush) begin
            r_cnt  <= '0;
        end else if (w_load) begin
            r_sreg <= fifo_dout;
            r_cnt  <= '0;
        end else if (w_shift) begin
            r_sreg <= r_sreg >> OUT_WIDTH;
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign fifo_rd_en = w_rd_en;
    assign out_valid  = (r_state == SHIFT);
    assign busy       = (r_state == SHIFT);
    assign out_data   = r_sreg[OUT_WIDTH-1:0];
    assign chunk_idx  = r_cnt;

`ifdef FIFO_UNPACK_LAST_EN
    assign out_last   = (r_state == SHIFT) && w_last_chunk;
`endif

endmodule

// File: tb/tb_fifo_unpack.sv
// tb_fifo_unpack -- scoreboard bench for fifo_unpack (32-bit words, 8-bit chunks)
// driving it from a registered-read FIFO model.
module tb_fifo_unpack;

    localparam int DW = 32;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_clr = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [1:0]    chunk_idx;
    logic          busy;
`ifdef FIFO_UNPACK_LAST_EN
    logic          out_last;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int illegal_pops = 0;

    typedef struct {
        logic [7:0] d;
        logic [1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   pop_q[$];
    int   hs_q[$];

    always #5 clk = ~clk;

    fifo_unpack #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .chunk_idx  (chunk_idx),
`ifdef FIFO_UNPACK_LAST_EN
        .out_last   (out_last),
`endif
        .busy       (busy)
    );

    // FIFO model: dout/empty registered from pre-edge pointers, so a pop at
    // edge e is visible only from cycle e+2.
    logic [DW-1:0] mem [0:7];
    logic [3:0]    wp, rp;
    always_ff @(posedge clk or negedge fifo_rst_n) begin
        if (!fifo_rst_n) begin
            wp <= '0; rp <= '0; fifo_empty <= 1'b1; fifo_dout <= '0;
        end else begin
            fifo_empty <= (wp == rp);
            fifo_dout  <= mem[rp[2:0]];
            if (fifo_clr) begin
                wp <= '0; rp <= '0;
            end else begin
                if (wr_en) begin
                    mem[wp[2:0]] <= wr_data;
                    wp <= wp + 4'd1;
                end
                if (fifo_rd_en && (wp != rp)) rp <= rp + 4'd1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops handshakes against the scoreboard, logs pops.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) begin
                pop_q.push_back(cyc);
                if (fifo_empty) illegal_pops++;
            end
            if (out_valid && out_ready) begin
                hs_q.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_chunk actual=%0h idx=%0d required=none", out_data, chunk_idx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e.d || chunk_idx !== e.idx) begin
                        failures++;
                        $display("FAIL chunk actual=%0h/%0d required=%0h/%0d", out_data, chunk_idx, e.d, e.idx);
                    end
`ifdef FIFO_UNPACK_LAST_EN
                    if (out_last !== (e.idx == 2'd3)) begin
                        failures++;
                        $display("FAIL out_last actual=%0b required=%0b", out_last, (e.idx == 2'd3));
                    end
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d   = w[8*i +: 8];
            e.idx = 2'(i);
            exp_q.push_back(e);
        end
    endtask

    task automatic fifo_write(input logic [31:0] w);
        wr_en = 1'b1; wr_data = w;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 60) begin tick(); n++; end
        chk(name, (n < 60), 1);
    endtask

    task automatic wait_idx(input logic [1:0] k, input string name);
        int n = 0;
        while (!(out_valid && chunk_idx == k) && n < 40) begin tick(); n++; end
        chk(name, (n < 40), 1);
    endtask

    task automatic clear_logs();
        pop_q.delete();
        hs_q.delete();
    endtask

    initial begin
        int c;
        #2;
        // Reset state
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_idx", chunk_idx, 0);
        chk("rst_data", out_data, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        tick(); tick();
        fifo_rst_n = 1'b1;
        rst_n = 1'b1;
        tick(); tick();

        // Single word
        out_ready = 1'b1;
        clear_logs();
        c = cyc;
        expect_word(32'h44332211, 4);
        fifo_write(32'h44332211);
        wait_drain("single_drain");
        chk("single_pops", pop_q.size(), 1);
        if (pop_q.size() == 1) chk("single_pop_cycle", pop_q[0], c + 2);
        chk("single_busy_low", busy, 0);
        tick(); tick();

        // Back-to-back
        clear_logs();
        expect_word(32'hA3A2A1A0, 4);
        expect_word(32'hB3B2B1B0, 4);
        fifo_write(32'hA3A2A1A0);
        fifo_write(32'hB3B2B1B0);
        wait_drain("b2b_drain");
        chk("b2b_hs_count", hs_q.size(), 8);
        if (hs_q.size() == 8) chk("b2b_gapfree", hs_q[7] - hs_q[0], 7);
        chk("b2b_pops", pop_q.size(), 2);
        if (pop_q.size() == 2) chk("b2b_pop_spacing", pop_q[1] - pop_q[0], 4);
        tick(); tick();

        // Backpressure 1,0,0,1
        clear_logs();
        expect_word(32'h0D0C0B0A, 4);
        fifo_write(32'h0D0C0B0A);
        wait_idx(2'd0, "bp_start");
        tick();
        out_ready = 1'b0;
        chk("bp_hold1_data", out_data, 8'h0B);
        chk("bp_hold1_idx", chunk_idx, 1);
        tick();
        chk("bp_hold2_data", out_data, 8'h0B);
        tick();
        out_ready = 1'b1;
        chk("bp_hold3_data", out_data, 8'h0B);
        wait_drain("bp_drain");
        chk("bp_hs_count", hs_q.size(), 4);
        chk("bp_pops", pop_q.size(), 1);
        tick(); tick();

        // Empty boundary: second word lands one cycle after the first pop
        clear_logs();
        expect_word(32'h87654321, 4);
        expect_word(32'hFEDCBA98, 4);
        fifo_write(32'h87654321);
        begin
            int n = 0;
            while (!fifo_rd_en && n < 20) begin tick(); n++; end
            chk("eb_first_pop", (n < 20), 1);
        end
        tick();
        fifo_write(32'hFEDCBA98);
        wait_drain("eb_drain");
        chk("eb_pops", pop_q.size(), 2);
        chk("eb_hs_count", hs_q.size(), 8);
        tick(); tick();

        // Flush mid-word with FIFO clear; queued second word is discarded
        clear_logs();
        expect_word(32'h13121110, 1);
        fifo_write(32'h13121110);
        fifo_write(32'h23222120);
        wait_idx(2'd1, "fl_reach_idx1");
        out_ready = 1'b0;
        flush = 1'b1;
        fifo_clr = 1'b1;
        pop_q.delete();
        tick();
        flush = 1'b0;
        fifo_clr = 1'b0;
        chk("fl_valid_low", out_valid, 0);
        chk("fl_busy_low", busy, 0);
        tick(); tick();
        chk("fl_no_pop", pop_q.size(), 0);
        chk("fl_sb_empty", exp_q.size(), 0);
        out_ready = 1'b1;
        expect_word(32'h33323130, 4);
        fifo_write(32'h33323130);
        wait_drain("fl_new_word");
        tick(); tick();

        // Asynchronous reset mid-word
        clear_logs();
        expect_word(32'h43424140, 2);
        fifo_write(32'h43424140);
        wait_idx(2'd2, "ar_reach_idx2");
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_idx", chunk_idx, 0);
        chk("ar_rd_en", fifo_rd_en, 0);
        tick(); tick();
        #2;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        expect_word(32'h53525150, 4);
        fifo_write(32'h53525150);
        wait_drain("ar_after_release");

        chk("illegal_pops", illegal_pops, 0);
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
